// File: rtl/ncl_bitserial_add_seq_if.sv
// rtl/ncl_bitserial_add_seq_if.sv - operand/result handshake bundle for the bit-serial NCL adder sequencer
//
// Purpose: groups the binary-side handshake of ncl_bitserial_add_seq.
// Signals:
//   in_valid/in_ready   operand handshake, transfer when both are 1 on a clk edge
//   in_a, in_b, in_cin  binary operands and carry-in
//   out_valid/out_ready result handshake, transfer when both are 1 on a clk edge
//   out_sum, out_cout   result and carry-out
// Modports: master = operand producer / result consumer, slave = the sequencer.

interface ncl_bitserial_add_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/ncl_bitserial_add_seq.sv
// rtl/ncl_bitserial_add_seq.sv - sequences a WIDTH-bit add through one external NCL full-adder cell
//
// Purpose: accepts binary operands, feeds them LSB first as dual-rail DATA/NULL
// wavefronts to an external NCL full-adder cell, collects the dual-rail results
// and presents the binary sum. Carry is chained through an internal register.
// Ports:
//   clk, init       clock, asynchronous active-high reset
//   bus (slave)     operand/result handshake (see ncl_bitserial_add_seq_if)
//   a_dr, b_dr, cin_dr          dual-rail operands to the cell (00 NULL, 01 zero, 10 one)
//   sumoutcomp, carryoutcomp    completion to the cell: 0 requests DATA, 1 requests NULL
//   sum_dr, cout_dr, incomp     dual-rail results and input completion from the cell
//   err                         sticky fault flag (illegal code or phase timeout)

module ncl_bitserial_add_seq #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 init,
  ncl_bitserial_add_seq_if.slave bus,
  output logic [1:0]           a_dr,
  output logic [1:0]           b_dr,
  output logic [1:0]           cin_dr,
  output logic                 sumoutcomp,
  output logic                 carryoutcomp,
  input  logic [1:0]           sum_dr,
  input  logic [1:0]           cout_dr,
  input  logic                 incomp,
  output logic                 err
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DRV_DATA, S_WAIT_DATA, S_DRV_NULL, S_WAIT_NULL, S_DONE, S_ERR
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q, b_q, acc_q, out_sum_q;
  logic               carry_q, out_cout_q;
  logic [IDX_W-1:0]   bit_idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         a_dr_q, b_dr_q, cin_dr_q;
  logic               comp_q, in_ready_q, out_valid_q, err_q;

  // The cell is asynchronous: every returned signal is double-flopped first.
  logic [1:0] sum_s1_q, sum_s2_q, cout_s1_q, cout_s2_q;
  logic       inc_s1_q, inc_s2_q;

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      sum_s1_q  <= 2'b00;
      sum_s2_q  <= 2'b00;
      cout_s1_q <= 2'b00;
      cout_s2_q <= 2'b00;
      inc_s1_q  <= 1'b0;
      inc_s2_q  <= 1'b0;
    end else begin
      sum_s1_q  <= sum_dr;
      sum_s2_q  <= sum_s1_q;
      cout_s1_q <= cout_dr;
      cout_s2_q <= cout_s1_q;
      inc_s1_q  <= incomp;
      inc_s2_q  <= inc_s1_q;
    end
  end

  function automatic logic [1:0] enc(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  logic data_ok, null_ok, fault, expired, last_bit;

  assign data_ok  = inc_s2_q && (sum_s2_q != 2'b00) && (cout_s2_q != 2'b00);
  assign null_ok  = !inc_s2_q && (sum_s2_q == 2'b00) && (cout_s2_q == 2'b00);
  assign fault    = ((sum_s2_q == 2'b11) || (cout_s2_q == 2'b11)) && (state_q != S_ERR);
  assign expired  = (cnt_q == CNT_W'(TIMEOUT - 1)) &&
                    (((state_q == S_WAIT_DATA) && !data_ok) ||
                     ((state_q == S_WAIT_NULL) && !null_ok));
  assign last_bit = (bit_idx_q == IDX_W'(WIDTH - 1));

  // Cell outputs change only on entry to DRV_DATA (operand bits) or DRV_NULL
  // (all NULL), so DATA is always separated from the next DATA by a NULL.
  // Operands are kept as shift registers: bit 0 of a_q/b_q is the next bit.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_sum_q   <= '0;
      carry_q     <= 1'b0;
      out_cout_q  <= 1'b0;
      bit_idx_q   <= '0;
      cnt_q       <= '0;
      a_dr_q      <= 2'b00;
      b_dr_q      <= 2'b00;
      cin_dr_q    <= 2'b00;
      comp_q      <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;

      if (fault || expired) begin
        state_q     <= S_ERR;
        err_q       <= 1'b1;
        a_dr_q      <= 2'b00;
        b_dr_q      <= 2'b00;
        cin_dr_q    <= 2'b00;
        comp_q      <= 1'b1;
        in_ready_q  <= 1'b0;
        out_valid_q <= 1'b0;
        cnt_q       <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            in_ready_q <= 1'b1;
            comp_q     <= 1'b0;
            if (bus.in_valid && in_ready_q) begin
              a_q        <= bus.in_a >> 1;
              b_q        <= bus.in_b >> 1;
              carry_q    <= bus.in_cin;
              bit_idx_q  <= '0;
              a_dr_q     <= enc(bus.in_a[0]);
              b_dr_q     <= enc(bus.in_b[0]);
              cin_dr_q   <= enc(bus.in_cin);
              in_ready_q <= 1'b0;
              state_q    <= S_DRV_DATA;
              cnt_q      <= '0;
            end
          end
          S_DRV_DATA: begin
            state_q <= S_WAIT_DATA;
            cnt_q   <= '0;
          end
          S_WAIT_DATA: begin
            if (data_ok) begin
              // Sum bits enter at the top; after WIDTH bits acc_q is LSB-aligned.
              acc_q    <= {sum_s2_q[1], acc_q[WIDTH-1:1]};
              carry_q  <= cout_s2_q[1];
              a_dr_q   <= 2'b00;
              b_dr_q   <= 2'b00;
              cin_dr_q <= 2'b00;
              comp_q   <= 1'b1;
              state_q  <= S_DRV_NULL;
              cnt_q    <= '0;
            end
          end
          S_DRV_NULL: begin
            state_q <= S_WAIT_NULL;
            cnt_q   <= '0;
          end
          S_WAIT_NULL: begin
            if (null_ok) begin
              comp_q <= 1'b0;
              cnt_q  <= '0;
              if (last_bit) begin
                out_sum_q   <= acc_q;
                out_cout_q  <= carry_q;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
                a_dr_q    <= enc(a_q[0]);
                b_dr_q    <= enc(b_q[0]);
                cin_dr_q  <= enc(carry_q);
                a_q       <= a_q >> 1;
                b_q       <= b_q >> 1;
                state_q   <= S_DRV_DATA;
              end
            end
          end
          S_DONE: begin
            if (bus.out_ready) begin
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= S_IDLE;
              cnt_q       <= '0;
            end
          end
          S_ERR: begin
            state_q <= S_ERR;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign a_dr          = a_dr_q;
  assign b_dr          = b_dr_q;
  assign cin_dr        = cin_dr_q;
  assign sumoutcomp    = comp_q;
  assign carryoutcomp  = comp_q;
  assign err           = err_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;

endmodule
